// File: rtl/chan_fifo_bridge.sv
// chan_fifo_bridge: per-channel host->app and app->host byte FIFOs behind the comm_fpga_fx2 channel bus,
// with depth readback on status addresses. Latency: push visible at the FIFO head one cycle later.
// Backpressure: ready = FIFO not full. Optional peak-depth watermarks: define CHAN_FIFO_BRIDGE_STATS_EN.

module chan_fifo_bridge_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  resetN_in,
    input  logic                  push_i,
    input  logic [7:0]            dat_i,
    input  logic                  pop_i,
    output logic [7:0]            head_o,
    output logic                  vld_o,
    output logic                  rdy_o,
    output logic [DEPTH_LOG2:0]   depth_o
);
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            mem_q [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   depth_q, depth_d;
    logic                  push_ok, pop_ok;

    assign vld_o   = (depth_q != '0);
    // Fullness uses the current depth only, so a pop cannot make room for a same-cycle push.
    assign rdy_o   = (depth_q != FULL);
    assign push_ok = push_i & rdy_o;
    assign pop_ok  = pop_i & vld_o;
    assign head_o  = vld_o ? mem_q[rd_ptr_q] : 8'h00;
    assign depth_o = depth_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        depth_d  = depth_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   depth_d = depth_q + 1'b1;
            2'b01:   depth_d = depth_q - 1'b1;
            default: depth_d = depth_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            depth_q  <= depth_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end
endmodule

// chan_fifo_bridge: decodes chanAddr_in onto NUM_CHAN write/read FIFO pairs plus status/watermark reads.
// Latency: host/app pushes appear at the opposite side one cycle later; status reads are combinational.
// Backpressure: h2fReady_out / rdReady_out drop only while the addressed FIFO is full.
module chan_fifo_bridge #(
    parameter int NUM_CHAN   = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int BASE_ADDR  = 0,
    parameter int STAT_ADDR  = 64
) (
    input  logic                    clk_in,
    input  logic                    resetN_in,
    input  logic [6:0]              chanAddr_in,
    input  logic [7:0]              h2fData_in,
    input  logic                    h2fValid_in,
    output logic                    h2fReady_out,
    output logic [7:0]              f2hData_out,
    output logic                    f2hValid_out,
    input  logic                    f2hReady_in,
    output logic [8*NUM_CHAN-1:0]   wrData_out,
    output logic [NUM_CHAN-1:0]     wrValid_out,
    input  logic [NUM_CHAN-1:0]     wrReady_in,
    input  logic [8*NUM_CHAN-1:0]   rdData_in,
    input  logic [NUM_CHAN-1:0]     rdValid_in,
    output logic [NUM_CHAN-1:0]     rdReady_out
);
    generate
        if (STAT_ADDR < BASE_ADDR + NUM_CHAN) begin : g_addr_overlap
            $error("chan_fifo_bridge: status range overlaps data channel range");
        end
    endgenerate

    logic [NUM_CHAN-1:0] sel_data;
    logic [NUM_CHAN-1:0] wf_push, rf_pop;
    logic [NUM_CHAN-1:0] wf_rdy, rf_vld;
    logic [7:0]          wf_head [NUM_CHAN];
    logic [7:0]          rf_head [NUM_CHAN];
    logic [DEPTH_LOG2:0] wf_depth [NUM_CHAN];
    logic [DEPTH_LOG2:0] rf_depth [NUM_CHAN];

    genvar k;
    generate
        for (k = 0; k < NUM_CHAN; k++) begin : g_chan
            chan_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_wr_fifo (
                .clk_in    (clk_in),
                .resetN_in (resetN_in),
                .push_i    (wf_push[k]),
                .dat_i     (h2fData_in),
                .pop_i     (wrReady_in[k]),
                .head_o    (wf_head[k]),
                .vld_o     (wrValid_out[k]),
                .rdy_o     (wf_rdy[k]),
                .depth_o   (wf_depth[k])
            );

            chan_fifo_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rd_fifo (
                .clk_in    (clk_in),
                .resetN_in (resetN_in),
                .push_i    (rdValid_in[k]),
                .dat_i     (rdData_in[8*k +: 8]),
                .pop_i     (rf_pop[k]),
                .head_o    (rf_head[k]),
                .vld_o     (rf_vld[k]),
                .rdy_o     (rdReady_out[k]),
                .depth_o   (rf_depth[k])
            );

            assign wrData_out[8*k +: 8] = wf_head[k];
        end
    endgenerate

`ifdef CHAN_FIFO_BRIDGE_STATS_EN
    logic [DEPTH_LOG2:0] wpeak_q [NUM_CHAN];
    logic [DEPTH_LOG2:0] wpeak_d [NUM_CHAN];
    logic [DEPTH_LOG2:0] rpeak_q [NUM_CHAN];
    logic [DEPTH_LOG2:0] rpeak_d [NUM_CHAN];
    logic [NUM_CHAN-1:0] wpeak_clr, rpeak_clr;
`endif

    always_comb begin
        sel_data     = '0;
        h2fReady_out = 1'b1;
        f2hValid_out = 1'b1;
        f2hData_out  = 8'h00;
`ifdef CHAN_FIFO_BRIDGE_STATS_EN
        wpeak_clr    = '0;
        rpeak_clr    = '0;
`endif
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (chanAddr_in == 7'(BASE_ADDR + i)) begin
                sel_data[i]  = 1'b1;
                h2fReady_out = wf_rdy[i];
                f2hValid_out = rf_vld[i];
                f2hData_out  = rf_head[i];
            end
            if (chanAddr_in == 7'(STAT_ADDR + 2*i)) begin
                f2hData_out = 8'(wf_depth[i]);
            end
            if (chanAddr_in == 7'(STAT_ADDR + 2*i + 1)) begin
                f2hData_out = 8'(rf_depth[i]);
            end
`ifdef CHAN_FIFO_BRIDGE_STATS_EN
            if (chanAddr_in == 7'(STAT_ADDR + 2*NUM_CHAN + 2*i)) begin
                f2hData_out  = 8'(wpeak_q[i]);
                wpeak_clr[i] = h2fValid_in;
            end
            if (chanAddr_in == 7'(STAT_ADDR + 2*NUM_CHAN + 2*i + 1)) begin
                f2hData_out  = 8'(rpeak_q[i]);
                rpeak_clr[i] = h2fValid_in;
            end
`endif
        end
    end

    // Only the addressed channel sees host traffic; status/unmapped writes fall on the floor.
    assign wf_push = sel_data & {NUM_CHAN{h2fValid_in}};
    assign rf_pop  = sel_data & {NUM_CHAN{f2hReady_in}};

`ifdef CHAN_FIFO_BRIDGE_STATS_EN
    always_comb begin
        for (int i = 0; i < NUM_CHAN; i++) begin
            wpeak_d[i] = wpeak_q[i];
            rpeak_d[i] = rpeak_q[i];
            if (wpeak_clr[i] || (wf_depth[i] > wpeak_q[i])) begin
                wpeak_d[i] = wf_depth[i];
            end
            if (rpeak_clr[i] || (rf_depth[i] > rpeak_q[i])) begin
                rpeak_d[i] = rf_depth[i];
            end
        end
    end

    always_ff @(posedge clk_in or negedge resetN_in) begin
        if (!resetN_in) begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                wpeak_q[i] <= '0;
                rpeak_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHAN; i++) begin
                wpeak_q[i] <= wpeak_d[i];
                rpeak_q[i] <= rpeak_d[i];
            end
        end
    end
`endif
endmodule

// File: tb/tb_chan_fifo_bridge.sv
// Bench for chan_fifo_bridge (NUM_CHAN=2, DEPTH_LOG2=4, BASE_ADDR=0, STAT_ADDR=64); queue-based reference model,
// constant vector table for address decode, directed corner sequences and a randomized phase.
module tb_chan_fifo_bridge;
    localparam int CAP  = 16;
    localparam int STAT = 64;
`ifdef CHAN_FIFO_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  chan_addr;
    logic [7:0]  h2f_dat;
    logic        h2f_vld;
    logic        h2f_rdy;
    logic [7:0]  f2h_dat;
    logic        f2h_vld;
    logic        f2h_rdy;
    logic [15:0] wr_dat;
    logic [1:0]  wr_vld;
    logic [1:0]  wr_rdy;
    logic [15:0] rd_dat;
    logic [1:0]  rd_vld;
    logic [1:0]  rd_rdy;

    int tests = 0;
    int fails = 0;

    logic [7:0] wq [2][$];
    logic [7:0] rq [2][$];
    int         wpk [2];
    int         rpk [2];

    typedef struct {
        logic [6:0] addr;
        logic [7:0] exp_dat;
        logic       exp_vld;
        logic       exp_rdy;
    } vec_t;
    vec_t tbl [14];

    chan_fifo_bridge #(.NUM_CHAN(2), .DEPTH_LOG2(4), .BASE_ADDR(0), .STAT_ADDR(64)) dut (
        .clk_in       (clk),
        .resetN_in    (rst_n),
        .chanAddr_in  (chan_addr),
        .h2fData_in   (h2f_dat),
        .h2fValid_in  (h2f_vld),
        .h2fReady_out (h2f_rdy),
        .f2hData_out  (f2h_dat),
        .f2hValid_out (f2h_vld),
        .f2hReady_in  (f2h_rdy),
        .wrData_out   (wr_dat),
        .wrValid_out  (wr_vld),
        .wrReady_in   (wr_rdy),
        .rdData_in    (rd_dat),
        .rdValid_in   (rd_vld),
        .rdReady_out  (rd_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        h2f_vld = 1'b0;
        f2h_rdy = 1'b0;
        wr_rdy  = 2'b00;
        rd_vld  = 2'b00;
        h2f_dat = 8'h00;
        rd_dat  = 16'h0000;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            wq[k].delete();
            rq[k].delete();
            wpk[k] = 0;
            rpk[k] = 0;
        end
    endtask

    // Expected outputs follow directly from queue occupancy and the address map.
    task automatic check_all(input string nm);
        logic [1:0]  ewv, err;
        logic [15:0] ewd;
        logic [7:0]  ed;
        logic        ev, er, bad;
        int          a, c;
        a   = int'(chan_addr);
        ewd = '0;
        for (int k = 0; k < 2; k++) begin
            ewv[k] = (wq[k].size() != 0);
            if (ewv[k]) ewd[8*k +: 8] = wq[k][0];
            err[k] = (rq[k].size() < CAP);
        end
        ed = 8'h00;
        ev = 1'b1;
        er = 1'b1;
        if (a < 2) begin
            er = (wq[a].size() < CAP);
            ev = (rq[a].size() != 0);
            if (ev) ed = rq[a][0];
        end else if (a >= STAT && a < STAT + 4) begin
            c  = (a - STAT) / 2;
            ed = 8'(((a % 2) == 1) ? rq[c].size() : wq[c].size());
        end else if (STATS && a >= STAT + 4 && a < STAT + 8) begin
            c  = (a - STAT - 4) / 2;
            ed = 8'(((a % 2) == 1) ? rpk[c] : wpk[c]);
        end
        bad = (wr_vld !== ewv) || (rd_rdy !== err) || (f2h_vld !== ev) || (h2f_rdy !== er) ||
              (ev && (f2h_dat !== ed));
        for (int k = 0; k < 2; k++) begin
            if (ewv[k] && (wr_dat[8*k +: 8] !== ewd[8*k +: 8])) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s addr=%0d: got wv=%b wd=%h rr=%b fd=%h fv=%b hr=%b want wv=%b wd=%h rr=%b fd=%h fv=%b hr=%b",
                     nm, a, wr_vld, wr_dat, rd_rdy, f2h_dat, f2h_vld, h2f_rdy, ewv, ewd, err, ed, ev, er);
        end
    endtask

    task automatic model_edge();
        int ws[2], rs[2];
        for (int k = 0; k < 2; k++) begin
            ws[k] = wq[k].size();
            rs[k] = rq[k].size();
        end
        if (STATS) begin
            for (int k = 0; k < 2; k++) begin
                if (h2f_vld && int'(chan_addr) == STAT + 4 + 2*k) wpk[k] = ws[k];
                else if (ws[k] > wpk[k]) wpk[k] = ws[k];
                if (h2f_vld && int'(chan_addr) == STAT + 5 + 2*k) rpk[k] = rs[k];
                else if (rs[k] > rpk[k]) rpk[k] = rs[k];
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (wr_rdy[k] && ws[k] > 0) void'(wq[k].pop_front());
            if (h2f_vld && int'(chan_addr) == k && ws[k] < CAP) wq[k].push_back(h2f_dat);
            if (f2h_rdy && int'(chan_addr) == k && rs[k] > 0) void'(rq[k].pop_front());
            if (rd_vld[k] && rs[k] < CAP) rq[k].push_back(rd_dat[8*k +: 8]);
        end
    endtask

    // Called at posedge+1 with inputs already set; returns at the following posedge+1.
    task automatic step(input string nm);
        #3;
        check_all(nm);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        clear_model();
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int r;
        rst_n     = 1'b0;
        chan_addr = 7'd0;
        idle_inputs();
        clear_model();
        #2;
        chk("rst_wrvalid", 16'(wr_vld), 16'h0);
        chk("rst_wrdata", wr_dat, 16'h0);
        chk("rst_rdready", 16'(rd_rdy), 16'h3);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset while three bytes sit in write-FIFO 0.
        chan_addr = 7'd0;
        h2f_vld   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h2f_dat = 8'hA0 + 8'(i);
            step("t1_fill");
        end
        h2f_vld = 1'b0;
        #1;
        chk("t1_wrvalid_before", 16'(wr_vld), 16'h1);
        rst_n     = 1'b0;
        chan_addr = 7'(STAT);
        clear_model();
        #1;
        chk("t1_mid_wrvalid", 16'(wr_vld), 16'h0);
        chk("t1_mid_depth", 16'(f2h_dat), 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("t1_rdready", 16'(rd_rdy), 16'h3);
        chk("t1_depth", 16'(f2h_dat), 16'h0);
        step("t1_after");

        // Two host writes, then app pops.
        chan_addr = 7'd0;
        h2f_vld   = 1'b1;
        h2f_dat   = 8'h11;
        step("t2_push11");
        chk("t2_head_11", 16'(wr_dat[7:0]), 16'h11);
        h2f_dat = 8'h22;
        step("t2_push22");
        h2f_vld = 1'b0;
        chk("t2_head_still_11", 16'(wr_dat[7:0]), 16'h11);
        wr_rdy = 2'b01;
        step("t2_pop1");
        chk("t2_head_22", 16'(wr_dat[7:0]), 16'h22);
        chk("t2_fifo1_idle", 16'(wr_vld[1]), 16'h0);
        step("t2_pop2");
        wr_rdy = 2'b00;
        chk("t2_empty", 16'(wr_vld), 16'h0);

        // Fill read-FIFO 1, then push+pop while full.
        rd_vld = 2'b10;
        for (int i = 0; i < CAP; i++) begin
            rd_dat = {8'h30 + 8'(i), 8'h00};
            step("t3_fill");
        end
        rd_vld = 2'b00;
        #1;
        chk("t3_full_rdready", 16'(rd_rdy[1]), 16'h0);
        chan_addr = 7'd1;
        f2h_rdy   = 1'b1;
        rd_vld    = 2'b10;
        rd_dat    = 16'hEE00;
        #1;
        chk("t3_head", 16'(f2h_dat), 16'h30);
        step("t3_pushpop_full");
        rd_vld    = 2'b00;
        f2h_rdy   = 1'b0;
        chan_addr = 7'(STAT + 3);
        #1;
        chk("t3_depth15", 16'(f2h_dat), 16'd15);
        chk("t3_ready_again", 16'(rd_rdy[1]), 16'h1);
        rd_vld = 2'b10;
        rd_dat = 16'hEF00;
        step("t3_push_after");
        rd_vld = 2'b00;
        #1;
        chk("t3_depth16", 16'(f2h_dat), 16'd16);
        chan_addr = 7'd1;
        f2h_rdy   = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            if (i == CAP - 1) begin
                #1;
                chk("t3_last_is_EF", 16'(f2h_dat), 16'hEF);
            end
            step("t3_drain");
        end
        f2h_rdy = 1'b0;

        // Status reads of depth and an unmapped address.
        do_reset();
        rd_vld = 2'b01;
        for (int i = 0; i < 5; i++) begin
            rd_dat = {8'h00, 8'h50 + 8'(i)};
            step("t4_fill");
        end
        rd_vld    = 2'b00;
        chan_addr = 7'(STAT + 1);
        #1;
        chk("t4_depth5", {7'h0, f2h_vld, f2h_dat}, 16'h0105);
        chan_addr = 7'd127;
        #1;
        chk("t4_addr127", {7'h0, f2h_vld, f2h_dat}, 16'h0100);

        // Known state for the decode table: wq0={A1,A2}, rq0=5 bytes, rq1={60,61,62}.
        chan_addr = 7'd0;
        h2f_vld   = 1'b1;
        h2f_dat   = 8'hA1;
        step("tbl_setup");
        h2f_dat = 8'hA2;
        step("tbl_setup");
        h2f_vld = 1'b0;
        rd_vld  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            rd_dat = {8'h60 + 8'(i), 8'h00};
            step("tbl_setup");
        end
        rd_vld = 2'b00;

        tbl[0]  = '{7'd0,   8'h50, 1'b1, 1'b1};
        tbl[1]  = '{7'd1,   8'h60, 1'b1, 1'b1};
        tbl[2]  = '{7'd2,   8'h00, 1'b1, 1'b1};
        tbl[3]  = '{7'd63,  8'h00, 1'b1, 1'b1};
        tbl[4]  = '{7'd64,  8'h02, 1'b1, 1'b1};
        tbl[5]  = '{7'd65,  8'h05, 1'b1, 1'b1};
        tbl[6]  = '{7'd66,  8'h00, 1'b1, 1'b1};
        tbl[7]  = '{7'd67,  8'h03, 1'b1, 1'b1};
        tbl[8]  = '{7'd68,  STATS ? 8'h02 : 8'h00, 1'b1, 1'b1};
        tbl[9]  = '{7'd69,  STATS ? 8'h05 : 8'h00, 1'b1, 1'b1};
        tbl[10] = '{7'd70,  8'h00, 1'b1, 1'b1};
        tbl[11] = '{7'd71,  STATS ? 8'h03 : 8'h00, 1'b1, 1'b1};
        tbl[12] = '{7'd72,  8'h00, 1'b1, 1'b1};
        tbl[13] = '{7'd127, 8'h00, 1'b1, 1'b1};
        for (int i = 0; i < 14; i++) begin
            chan_addr = tbl[i].addr;
            #1;
            tests++;
            if ({f2h_dat, f2h_vld, h2f_rdy} !== {tbl[i].exp_dat, tbl[i].exp_vld, tbl[i].exp_rdy}) begin
                fails++;
                $display("FAIL tbl[%0d] addr=%0d: got dat=%h vld=%b rdy=%b want dat=%h vld=%b rdy=%b",
                         i, tbl[i].addr, f2h_dat, f2h_vld, h2f_rdy, tbl[i].exp_dat, tbl[i].exp_vld, tbl[i].exp_rdy);
            end
        end
        #1;

        // 40 push/pop pairs on write-FIFO 1 straddling pointer wrap.
        do_reset();
        chan_addr = 7'd1;
        h2f_vld   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h2f_dat = 8'(i + 1);
            step("t5_prefill");
        end
        wr_rdy = 2'b10;
        for (int i = 0; i < 40; i++) begin
            h2f_dat = 8'($urandom);
            step("t5_pair");
        end
        h2f_vld   = 1'b0;
        wr_rdy    = 2'b00;
        chan_addr = 7'(STAT + 2);
        #1;
        chk("t5_depth3", 16'(f2h_dat), 16'd3);
        wr_rdy = 2'b10;
        for (int i = 0; i < 3; i++) step("t5_drain");
        wr_rdy = 2'b00;
        chk("t5_empty", 16'(wr_vld), 16'h0);

`ifdef CHAN_FIFO_BRIDGE_STATS_EN
        do_reset();
        chan_addr = 7'd0;
        h2f_vld   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            h2f_dat = 8'(i);
            step("t6_fill");
        end
        h2f_vld = 1'b0;
        wr_rdy  = 2'b01;
        for (int i = 0; i < 7; i++) step("t6_drain");
        wr_rdy    = 2'b00;
        chan_addr = 7'(STAT + 4);
        #1;
        chk("t6_peak9", 16'(f2h_dat), 16'd9);
        h2f_vld = 1'b1;
        step("t6_clear");
        h2f_vld = 1'b0;
        #1;
        chk("t6_peak2", 16'(f2h_dat), 16'd2);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 11);
            if (r < 5)       chan_addr = 7'(r % 2);
            else if (r < 9)  chan_addr = 7'(STAT + r - 5);
            else if (r == 9) chan_addr = 7'(STAT + 4 + $urandom_range(0, 3));
            else if (r == 10) chan_addr = 7'd127;
            else             chan_addr = 7'($urandom_range(2, 63));
            h2f_vld = 1'($urandom);
            h2f_dat = 8'($urandom);
            f2h_rdy = 1'($urandom);
            wr_rdy  = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            rd_vld  = 2'($urandom);
            rd_dat  = 16'($urandom);
            step("rand");
        end
        idle_inputs();
        step("rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
